spi_input_conditioner: RTL and testbench

Front-end stage of the SPI slave: takes the three raw pin inputs (serial clock, chip select, MOSI) and produces synchronized, debounced levels plus single-cycle rising/falling edge strobes in the `s_clk` domain. Its outputs feed the SPI control FSM and shift register directly downstream. Conditioned chip select drives the FSM `CS` input. The serial-clock edge strobes pace bit shifting and FSM state advance. Each of the three channels is an independent copy of the same synchronize → debounce → edge-detect pipeline.

---
 rtl/spi_input_conditioner.sv | 106 ++++++++++
 tb/tb_spi_input_conditioner.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_input_conditioner.sv
// Raw SPI pin conditioning: each of sclk/cs/mosi is synchronized, debounced and
// edge-detected in the s_clk domain by an identical per-channel pipeline.

module spi_input_conditioner_ch #(
    parameter int   COUNTER_WIDTH = 3,
    parameter int   WAIT_TIME     = 3,
    parameter logic RESET_BIT     = 1'b0
) (
    input  logic s_clk,
    input  logic reset,
    input  logic noisy,
    output logic conditioned,
    output logic positiveedge,
    output logic negativeedge
);

    localparam logic [COUNTER_WIDTH-1:0] WAIT_CNT = COUNTER_WIDTH'(WAIT_TIME);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);

    logic                     sync0;
    logic                     sync1;
    logic [COUNTER_WIDTH-1:0] cnt;
    logic                     mismatch;
    logic                     accept;

    assign mismatch = (sync1 != conditioned);
    // A new level is taken only after WAIT_TIME+1 back-to-back mismatching samples.
    assign accept   = mismatch && (cnt == WAIT_CNT);

    always_ff @(posedge s_clk) begin
        if (reset) begin
            sync0 <= RESET_BIT;
            sync1 <= RESET_BIT;
        end else begin
            sync0 <= noisy;
            sync1 <= sync0;
        end
    end

    always_ff @(posedge s_clk) begin
        if (reset) begin
            cnt         <= '0;
            conditioned <= RESET_BIT;
        end else if (!mismatch) begin
            cnt <= '0;
        end else if (accept) begin
            cnt         <= '0;
            conditioned <= sync1;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Strobes derive from the accept decision, so reset can never fire one.
    always_ff @(posedge s_clk) begin
        if (reset) begin
            positiveedge <= 1'b0;
            negativeedge <= 1'b0;
        end else begin
            positiveedge <= accept &  sync1;
            negativeedge <= accept & ~sync1;
        end
    end

endmodule

module spi_input_conditioner #(
    parameter int         COUNTER_WIDTH = 3,
    parameter int         WAIT_TIME     = 3,
    parameter logic [2:0] RESET_VALUE   = 3'b010
) (
    input  logic       s_clk,
    input  logic       reset,
    input  logic [2:0] noisy,
    output logic [2:0] conditioned,
    output logic [2:0] positiveedge,
    output logic [2:0] negativeedge
);

    localparam int NUM_CH = 3;

    generate
        if (WAIT_TIME >= (1 << COUNTER_WIDTH)) begin : g_bad_param
            $error("WAIT_TIME must fit in COUNTER_WIDTH bits");
        end
    endgenerate

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            spi_input_conditioner_ch #(
                .COUNTER_WIDTH (COUNTER_WIDTH),
                .WAIT_TIME     (WAIT_TIME),
                .RESET_BIT     (RESET_VALUE[i])
            ) u_ch (
                .s_clk        (s_clk),
                .reset        (reset),
                .noisy        (noisy[i]),
                .conditioned  (conditioned[i]),
                .positiveedge (positiveedge[i]),
                .negativeedge (negativeedge[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_spi_input_conditioner.sv
// Bench for spi_input_conditioner: directed timing scenarios plus random pin
// activity, all checked every cycle against a window-based behavioural model.

module tb_spi_input_conditioner;

    localparam int         W  = 3;
    localparam logic [2:0] RV = 3'b010;

    logic       s_clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] noisy = 3'b000;
    logic [2:0] conditioned, positiveedge, negativeedge;

    int checks = 0;
    int errors = 0;

    spi_input_conditioner #(
        .COUNTER_WIDTH (3),
        .WAIT_TIME     (W),
        .RESET_VALUE   (RV)
    ) dut (
        .s_clk        (s_clk),
        .reset        (reset),
        .noisy        (noisy),
        .conditioned  (conditioned),
        .positiveedge (positiveedge),
        .negativeedge (negativeedge)
    );

    always #5 s_clk = ~s_clk;

    // Model: a level is accepted at edge e when the W+1 most recent synchronized
    // samples (all taken after the last change/reset) disagree with the output.
    logic [2:0] m_s0 = RV, m_s1 = RV, m_cond = RV, m_pe = '0, m_ne = '0;
    logic [2:0] win[$];
    int         anchor[3] = '{-100, -100, -100};
    int         e = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit all_diff;
        e++;
        if (reset) begin
            m_s0 = RV; m_s1 = RV; m_cond = RV; m_pe = '0; m_ne = '0;
            win.delete();
            for (int c = 0; c < 3; c++) anchor[c] = e;
        end else begin
            win.push_back(m_s1);
            if (win.size() > W + 1) void'(win.pop_front());
            m_pe = '0; m_ne = '0;
            for (int c = 0; c < 3; c++) begin
                if (e - anchor[c] >= W + 1) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < win.size(); j++)
                        if (win[j][c] == m_cond[c]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_cond[c] = ~m_cond[c];
                        if (m_cond[c]) m_pe[c] = 1'b1; else m_ne[c] = 1'b1;
                        anchor[c] = e;
                    end
                end
            end
            m_s1 = m_s0;
            m_s0 = noisy;
        end
    endtask

    task automatic tick();
        @(posedge s_clk);
        model_step();
        @(negedge s_clk);
        chk("model", {23'd0, conditioned, positiveedge, negativeedge},
                     {23'd0, m_cond, m_pe, m_ne});
    endtask

    // One capture tick, then count ticks until the selected strobe appears.
    task automatic measure(input bit pos, input int ch, output int n);
        tick();
        n = 0;
        do begin
            tick();
            n++;
        end while (!(pos ? positiveedge[ch] : negativeedge[ch]) && n < 20);
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hi, npe, nne;
        bit moved;
        int hold[3];

        // Reset with all pins low, then cs falls through the debouncer.
        @(negedge s_clk);
        reset = 1'b1; noisy = 3'b000;
        run(2);
        chk("rst_cond", {29'd0, conditioned}, {29'd0, RV});
        chk("rst_strobe", {26'd0, positiveedge, negativeedge}, 32'd0);
        reset = 1'b0;
        measure(1'b0, 1, n);
        chk("rst_release_cs_lat", n, 5);
        chk("rst_release_cs_lvl", {31'd0, conditioned[1]}, 32'd0);

        // sclk rising
        noisy = 3'b010;
        run(10);
        noisy[0] = 1'b1;
        measure(1'b1, 0, n);
        chk("sclk_rise_lat", n, 5);
        chk("sclk_rise_lvl", {31'd0, conditioned[0]}, 32'd1);
        tick();
        chk("sclk_strobe_1cyc", {31'd0, positiveedge[0]}, 32'd0);
        run(8);

        // mosi glitch of 3 cycles is rejected
        noisy[2] = 1'b1; run(3); noisy[2] = 1'b0;
        moved = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (conditioned[2] || positiveedge[2] || negativeedge[2]) moved = 1'b1;
        end
        chk("glitch3_rejected", {31'd0, moved}, 32'd0);

        // mosi pulse of 4 cycles passes with its width intact
        noisy[2] = 1'b1; run(4); noisy[2] = 1'b0;
        hi = 0; npe = 0; nne = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            hi  += int'(conditioned[2]);
            npe += int'(positiveedge[2]);
            nne += int'(negativeedge[2]);
        end
        chk("pulse4_width", hi, 4);
        chk("pulse4_pe", npe, 1);
        chk("pulse4_ne", nne, 1);

        // cs fall and restore
        noisy[1] = 1'b0;
        measure(1'b0, 1, n);
        chk("cs_fall_lat", n, 5);
        run(6);
        noisy[1] = 1'b1;
        measure(1'b1, 1, n);
        chk("cs_rise_lat", n, 5);
        run(6);

        // Reset mid-count with input ending up matching the reset level.
        noisy[0] = 1'b0;
        run(4);
        reset = 1'b1;
        tick();
        chk("rst_mid_cond", {29'd0, conditioned}, {29'd0, RV});
        chk("rst_mid_strobe", {26'd0, positiveedge, negativeedge}, 32'd0);
        reset = 1'b0;
        run(8);

        // Reset mid-count with input still mismatching afterwards.
        noisy[0] = 1'b1;
        run(4);
        reset = 1'b1;
        tick();
        chk("rst_mid2_cond0", {31'd0, conditioned[0]}, {31'd0, RV[0]});
        chk("rst_mid2_strobe", {26'd0, positiveedge, negativeedge}, 32'd0);
        reset = 1'b0;
        measure(1'b1, 0, n);
        chk("rst_mid2_relat", n, 5);
        run(8);

        // All channels toggle on the same edge (currently 011 -> 100).
        noisy = ~noisy;
        tick();
        n = 0;
        do begin
            tick();
            n++;
        end while ({positiveedge, negativeedge} == 6'd0 && n < 20);
        chk("all_lat", n, 5);
        chk("all_pe", {29'd0, positiveedge}, 32'h4);
        chk("all_ne", {29'd0, negativeedge}, 32'h3);
        chk("all_cond", {29'd0, conditioned}, 32'h4);
        run(8);

        // Random pin activity with occasional resets.
        for (int c = 0; c < 3; c++) hold[c] = $urandom_range(1, 8);
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < 3; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    noisy[c] = ~noisy[c];
                    hold[c] = $urandom_range(1, 8);
                end
            end
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;
        run(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
